// File: rtl/keystream_collector.sv
`default_nettype none
// ============================================================================
//  Module      : keystream_collector
//  Description : Deskews the permuter series' staggered 2048-bit to_mem bus
//                into one coherent block per accepted seed, then drains that
//                block as 64 x 32-bit words through a ready/valid memory
//                write port into consecutive 64-word address regions.
//  Revision    : 1.0 - initial release
// ============================================================================
module keystream_collector #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [2047:0]     to_mem,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              done,
    output logic [ADDR_W-7:0] blk_cnt
);

    localparam int               c_GROUP_W    = 192;
    localparam int               c_FULL_GRPS  = 10;
    localparam int               c_TAIL_LSB   = 1920;
    localparam int               c_TAIL_W     = 128;
    localparam logic [3:0]       c_LAST_GROUP = 4'd10;
    localparam logic [5:0]       c_LAST_WORD  = 6'd63;
    localparam logic [ADDR_W-7:0] c_BLK_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_word_acc;
    logic                w_blk_last;
    logic [3:0]          r_fc;
    logic [5:0]          r_w;
    logic [ADDR_W-7:0]   r_blk;
    logic                r_done;
    logic [2047:0]       r_buf;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus word-accept / block-complete strobes
    always_comb begin
        w_state_nxt = r_state;
        w_word_acc  = 1'b0;
        w_blk_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (seed_valid) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (r_fc == c_LAST_GROUP) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_word_acc = mem_ready;
                if (mem_ready && (r_w == c_LAST_WORD)) begin
                    w_blk_last  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fill/word counters, completed-block count and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc   <= 4'd0;
            r_w    <= 6'd0;
            r_blk  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_blk_last;
            if (w_blk_last) begin
                r_blk <= r_blk + c_BLK_ONE;
            end
            if (r_state == S_FILL) begin
                r_fc <= (r_fc == c_LAST_GROUP) ? 4'd0 : r_fc + 4'd1;
            end else begin
                r_fc <= 4'd0;
            end
            // The 6-bit index wraps 63 -> 0 on the final word by itself.
            if (w_word_acc) begin
                r_w <= r_w + 6'd1;
            end
        end
    end

    // Capture group fc on each FILL edge; stage k's output is valid exactly
    // k+1 edges after the accept, which is when fc equals k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
        end else if (r_state == S_FILL) begin
            for (int k = 0; k < c_FULL_GRPS; k++) begin
                if (r_fc == 4'(k)) begin
                    r_buf[k*c_GROUP_W +: c_GROUP_W] <= to_mem[k*c_GROUP_W +: c_GROUP_W];
                end
            end
            if (r_fc == c_LAST_GROUP) begin
                r_buf[c_TAIL_LSB +: c_TAIL_W] <= to_mem[c_TAIL_LSB +: c_TAIL_W];
            end
        end
    end

    assign seed_ready = (r_state == S_IDLE);
    assign mem_we     = (r_state == S_DRAIN);
    assign mem_addr   = {r_blk, r_w};
    assign mem_data   = r_buf[{r_w, 5'b00000} +: 32];
    assign done       = r_done;
    assign blk_cnt    = r_blk;

endmodule
`default_nettype wire

// File: tb/tb_keystream_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keystream_collector
//  Description : Self-checking bench for keystream_collector. Two instances
//                (ADDR_W=10 and ADDR_W=7) share stimulus; expected words and
//                addresses come from a block-level model of the collector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keystream_collector;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          seed_valid = 1'b0;
    logic [2047:0] to_mem = '0;
    logic          mem_ready = 1'b0;

    logic          a_seed_ready, a_mem_we, a_done;
    logic [9:0]    a_mem_addr;
    logic [31:0]   a_mem_data;
    logic [3:0]    a_blk_cnt;

    logic          b_seed_ready, b_mem_we, b_done;
    logic [6:0]    b_mem_addr;
    logic [31:0]   b_mem_data;
    logic [0:0]    b_blk_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int nblk     = 0;   // blocks completed since the last reset

    keystream_collector #(.ADDR_W(10)) u_dut_a (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(a_seed_ready),
        .to_mem(to_mem), .mem_we(a_mem_we), .mem_ready(mem_ready),
        .mem_addr(a_mem_addr), .mem_data(a_mem_data), .done(a_done), .blk_cnt(a_blk_cnt)
    );

    keystream_collector #(.ADDR_W(7)) u_dut_b (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(b_seed_ready),
        .to_mem(to_mem), .mem_we(b_mem_we), .mem_ready(mem_ready),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data), .done(b_done), .blk_cnt(b_blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2047:0] rand_bus();
        logic [2047:0] v;
        for (int i = 0; i < 64; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Group k carries byte k+1 everywhere; all other bits are 0xFF.
    function automatic logic [2047:0] deskew_bus(input int k);
        logic [2047:0] v;
        logic [7:0]    bt;
        v  = '1;
        bt = 8'(k + 1);
        if (k < 10) v[k*192 +: 192] = {24{bt}};
        else        v[1920 +: 128]  = {16{bt}};
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        seed_valid = 1'b0;
        repeat (n) begin
            mem_ready = 1'($urandom);
            tick();
            chk("idle_we_a", a_mem_we, 0);
            chk("idle_we_b", b_mem_we, 0);
            chk("idle_done_a", a_done, 0);
            chk("idle_seed_ready_a", a_seed_ready, 1);
        end
    endtask

    // One seed: accept, 11 fill cycles, then drain with the chosen ready
    // pattern. dmode=1 uses the deskew pattern; rmode 0=always ready,
    // 1=1,0,0 repeating, 2=random. abort_at>=0 resets after that word.
    task automatic run_block(input int dmode, input int rmode, input bit hold, input int abort_at);
        logic [2047:0] v;
        logic [2047:0] exp_blk;
        logic [31:0]   ew;
        logic [7:0]    bt;
        int            w;
        int            c;
        exp_blk = '0;
        chk("accept_seed_ready_a", a_seed_ready, 1);
        chk("accept_seed_ready_b", b_seed_ready, 1);
        chk("accept_we_a", a_mem_we, 0);
        seed_valid = 1'b1;
        to_mem     = rand_bus();
        mem_ready  = 1'($urandom);
        tick();
        seed_valid = hold;
        for (int k = 0; k < 11; k++) begin
            chk("fill_seed_ready_a", a_seed_ready, 0);
            chk("fill_we_a", a_mem_we, 0);
            chk("fill_we_b", b_mem_we, 0);
            chk("fill_done_a", a_done, 0);
            v = (dmode != 0) ? deskew_bus(k) : rand_bus();
            to_mem = v;
            if (k < 10) exp_blk[k*192 +: 192] = v[k*192 +: 192];
            else        exp_blk[1920 +: 128]  = v[1920 +: 128];
            mem_ready = 1'($urandom);
            tick();
        end
        to_mem = rand_bus();
        w = 0;
        c = 0;
        while (w < 64 && c < 2000) begin
            if (dmode != 0) begin
                bt = (w < 60) ? 8'(w / 6 + 1) : 8'd11;
                ew = {4{bt}};
            end else begin
                ew = exp_blk[w*32 +: 32];
            end
            chk("drain_we_a", a_mem_we, 1);
            chk("drain_we_b", b_mem_we, 1);
            chk("drain_done_a", a_done, 0);
            chk("drain_addr_a", a_mem_addr, 64'((nblk % 16) * 64 + w));
            chk("drain_addr_b", b_mem_addr, 64'((nblk % 2) * 64 + w));
            chk("drain_data_a", a_mem_data, ew);
            chk("drain_data_b", b_mem_data, ew);
            case (rmode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ((c % 3) == 0);
                default: mem_ready = 1'($urandom);
            endcase
            tick();
            if (mem_ready) w++;
            c++;
            if (abort_at >= 0 && w == abort_at + 1) begin
                chk("abort_pre_we_a", a_mem_we, 1);
                seed_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("abort_we_a", a_mem_we, 0);
                chk("abort_we_b", b_mem_we, 0);
                chk("abort_blk_a", a_blk_cnt, 0);
                chk("abort_blk_b", b_blk_cnt, 0);
                chk("abort_seed_ready_a", a_seed_ready, 1);
                chk("abort_addr_a", a_mem_addr, 0);
                chk("abort_data_a", a_mem_data, 0);
                chk("abort_done_a", a_done, 0);
                tick();
                rst  = 1'b0;
                nblk = 0;
                return;
            end
        end
        chk("drain_budget", 64'(w), 64);
        nblk++;
        chk("done_a", a_done, 1);
        chk("done_b", b_done, 1);
        chk("done_seed_ready_a", a_seed_ready, 1);
        chk("done_we_a", a_mem_we, 0);
        chk("blk_cnt_a", a_blk_cnt, 64'(nblk % 16));
        chk("blk_cnt_b", b_blk_cnt, 64'(nblk % 2));
    endtask

    initial begin
        // Asynchronous reset check, before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_we_a", a_mem_we, 0);
        chk("rst_done_a", a_done, 0);
        chk("rst_blk_a", a_blk_cnt, 0);
        chk("rst_seed_ready_a", a_seed_ready, 1);
        chk("rst_addr_a", a_mem_addr, 0);
        chk("rst_data_a", a_mem_data, 0);
        chk("rst_seed_ready_b", b_seed_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        idle(5);

        run_block(1, 0, 1'b0, -1);   // deskew pattern, always ready
        idle(2);
        run_block(0, 1, 1'b0, -1);   // backpressure 1,0,0,...
        idle(1);
        run_block(0, 0, 1'b1, -1);   // seed_valid held high: back-to-back
        run_block(0, 0, 1'b1, -1);
        idle(3);
        run_block(0, 2, 1'b0, -1);   // random ready; fifth block exercises wrap
        idle(2);
        run_block(0, 2, 1'b0, 20);   // reset after word 20
        idle(2);
        run_block(0, 2, 1'b0, -1);   // fresh block restarts at address 0
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
